// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Sequences the serial receive path around the header detector. While hunting
// it enables the detector; on the detector's wake pulse it captures a CNT_W-bit
// length field (MSB first) from sin, forwards exactly that many payload bits on
// dout/dout_valid, and then hands the frame to the transmitter through a
// start/busy handshake before re-arming the detector.
//
// Parameters
//   CNT_W      width of the length field and payload bit counter (>= 2)
//   FCNT_W     width of the completed-frame counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   sin        in   serial data line
//   gb         in   global enable; low parks the block in IDLE
//   det_wake   in   one-cycle pulse from the detector: header complete
//   tx_busy    in   transmitter busy flag
//   det_en     out  detector enable (high only while hunting)
//   dout       out  registered payload bit
//   dout_valid out  dout carries a payload bit this cycle
//   tx_start   out  request to transmitter (combinational from state/tx_busy)
//   frame_done out  one-cycle pulse when the frame has been fully transmitted
//   busy       out  high in every state except IDLE and HUNT
//   frame_cnt  out  count of completed frames, wraps
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              gb,
    input  logic              det_wake,
    input  logic              tx_busy,
    output logic              det_en,
    output logic              dout,
    output logic              dout_valid,
    output logic              tx_start,
    output logic              frame_done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_HANDOFF,
        S_TX_ACK,
        S_TX_DRAIN
    } state_t;

    // In LEN the counter indexes length bits 0..CNT_W-1; in PAYLOAD it holds
    // the number of payload bits still to be sampled.
    localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dout_q, dout_d;
    logic                dv_q, dv_d;
    logic                done_q, done_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    len_full;
    logic                tx_start_c;

    // Length value including the bit being sampled on this edge.
    assign len_full = {len_q[CNT_W-2:0], sin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        dout_d     = 1'b0;
        dv_d       = 1'b0;
        done_d     = 1'b0;
        fcnt_d     = fcnt_q;
        tx_start_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gb) begin
                    state_d = S_HUNT;
                end
            end

            S_HUNT: begin
                // Losing the global enable wins over a coincident wake.
                if (!gb) begin
                    state_d = S_IDLE;
                end else if (det_wake) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                    len_d   = '0;
                end
            end

            S_LEN: begin
                if (!gb) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    len_d   = '0;
                end else begin
                    len_d = len_full;
                    if (cnt_q == LEN_LAST) begin
                        // An empty frame silently re-arms the detector.
                        if (len_full == '0) begin
                            state_d = S_HUNT;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_PAYLOAD;
                            cnt_d   = len_full;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_PAYLOAD: begin
                if (!gb) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    len_d   = '0;
                end else begin
                    dout_d = sin;
                    dv_d   = 1'b1;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_HANDOFF;
                    end
                end
            end

            S_HANDOFF: begin
                // Request is withheld while the transmitter is still busy.
                if (!tx_busy) begin
                    tx_start_c = 1'b1;
                    state_d    = S_TX_ACK;
                end
            end

            S_TX_ACK: begin
                if (tx_busy) begin
                    state_d = S_TX_DRAIN;
                end
            end

            S_TX_DRAIN: begin
                // gb is only honoured once the transfer has completed.
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 1'b1;
                    state_d = gb ? S_HUNT : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign det_en     = (state_q == S_HUNT);
    assign busy       = (state_q != S_IDLE) && (state_q != S_HUNT);
    assign tx_start   = tx_start_c;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

    localparam int CNT_W  = 4;
    localparam int FCNT_W = 8;

    logic              clk;
    logic              rst;
    logic              sin;
    logic              gb;
    logic              det_wake;
    logic              tx_busy;
    logic              det_en;
    logic              dout;
    logic              dout_valid;
    logic              tx_start;
    logic              frame_done;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    frame_sequencer #(
        .CNT_W  (CNT_W),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .gb         (gb),
        .det_wake   (det_wake),
        .tx_busy    (tx_busy),
        .det_en     (det_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .tx_start   (tx_start),
        .frame_done (frame_done),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: expected payload stream and completed-frame count.
    logic exp_q[$];
    logic got_q[$];
    int   exp_cnt = 0;
    int   n_start = 0;
    int   n_done  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Observer: records what the DUT emits, well clear of both clock edges.
    always @(negedge clk) begin
        #2;
        if (dout_valid === 1'b1) got_q.push_back(dout);
        if (tx_start === 1'b1) n_start++;
        if (frame_done === 1'b1) n_done++;
    end

    task automatic sb_bits(input string tag);
        int n;
        chk({tag, "_nbits"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_bit"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Drives one frame starting from HUNT and checks it cycle by cycle.
    task automatic run_frame(input int len, input logic [15:0] pay, input int pre_busy,
                             input int hold, input bit drop, input bit noise);
        int s0;
        int d0;
        logic [CNT_W-1:0] lv;
        s0 = n_start;
        d0 = n_done;
        lv = CNT_W'(len);
        det_wake = 1'b1;
        sin = 1'($urandom);
        nxt();
        #1;
        chk("busy_len", busy, 1);
        chk("det_en_len", det_en, 0);
        for (int i = CNT_W - 1; i >= 0; i--) begin
            det_wake = noise ? 1'($urandom) : 1'b0;
            sin = lv[i];
            nxt();
        end
        det_wake = 1'b0;
        #1;
        if (len == 0) begin
            chk("empty_det_en", det_en, 1);
            chk("empty_busy", busy, 0);
            chk("empty_dv", dout_valid, 0);
            chk("empty_start", tx_start, 0);
            chk("empty_cnt", frame_cnt, exp_cnt);
            chk("empty_nstart", n_start - s0, 0);
            chk("empty_ndone", n_done - d0, 0);
        end else begin
            chk("dv_pre", dout_valid, 0);
            for (int k = 0; k < len; k++) begin
                det_wake = noise ? 1'($urandom) : 1'b0;
                sin = pay[k];
                exp_q.push_back(pay[k]);
                nxt();
                #1;
                chk("dv", dout_valid, 1);
                chk("dout", dout, pay[k]);
                chk("busy_pay", busy, 1);
            end
            det_wake = 1'b0;
            for (int p = 0; p < pre_busy; p++) begin
                tx_busy = 1'b1;
                #1;
                chk("start_held", tx_start, 0);
                nxt();
            end
            tx_busy = 1'b0;
            #1;
            chk("start", tx_start, 1);
            nxt();
            #1;
            chk("start_1cyc", tx_start, 0);
            chk("dv_post", dout_valid, 0);
            chk("busy_ack", busy, 1);
            if (drop) gb = 1'b0;
            tx_busy = 1'b1;
            for (int h = 0; h < hold; h++) begin
                det_wake = noise ? 1'($urandom) : 1'b0;
                nxt();
                #1;
                chk("done_early", frame_done, 0);
            end
            det_wake = 1'b0;
            tx_busy = 1'b0;
            nxt();
            #1;
            exp_cnt = (exp_cnt + 1) % (1 << FCNT_W);
            chk("done", frame_done, 1);
            chk("frame_cnt", frame_cnt, exp_cnt);
            chk("rearm", det_en, drop ? 0 : 1);
            chk("busy_end", busy, 0);
            nxt();
            #1;
            chk("done_1cyc", frame_done, 0);
            if (drop) begin
                chk("idle_after_drop", det_en, 0);
                gb = 1'b1;
                nxt();
                #1;
                chk("hunt_again", det_en, 1);
            end
            chk("nstart", n_start - s0, 1);
            chk("ndone", n_done - d0, 1);
        end
        sb_bits("frame");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int d0;
        rst = 1'b1;
        sin = 1'b0;
        gb = 1'b0;
        det_wake = 1'b0;
        tx_busy = 1'b0;
        nxt();
        nxt();
        chk("rst_det_en", det_en, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dv", dout_valid, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        nxt();
        #1;
        chk("idle_det_en", det_en, 0);
        gb = 1'b1;
        nxt();
        #1;
        chk("hunt_det_en", det_en, 1);
        chk("hunt_busy", busy, 0);

        // Basic frame: length 3, payload 1,0,1, transmitter busy for 4 cycles.
        run_frame(3, 16'b101, 0, 4, 1'b0, 1'b0);
        // Empty frame.
        run_frame(0, 16'h0, 0, 1, 1'b0, 1'b0);
        // Transmitter busy when the handoff begins.
        run_frame(6, 16'b110010, 3, 2, 1'b0, 1'b0);

        // gb dropped on the 2nd of 5 payload bits.
        s0 = n_start;
        d0 = n_done;
        det_wake = 1'b1;
        nxt();
        det_wake = 1'b0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            sin = (i == 2 || i == 0);
            nxt();
        end
        sin = 1'b1;
        exp_q.push_back(1'b1);
        nxt();
        #1;
        chk("abort_dv1", dout_valid, 1);
        gb = 1'b0;
        sin = 1'b0;
        nxt();
        #1;
        chk("abort_dv", dout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_det_en", det_en, 0);
        for (int i = 0; i < 4; i++) nxt();
        chk("abort_nstart", n_start - s0, 0);
        chk("abort_ndone", n_done - d0, 0);
        chk("abort_cnt", frame_cnt, exp_cnt);
        sb_bits("abort");
        gb = 1'b1;
        nxt();
        #1;
        chk("abort_rehunt", det_en, 1);

        // gb dropped while the transmitter drains.
        run_frame(2, 16'b01, 1, 3, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the length field.
        det_wake = 1'b1;
        nxt();
        det_wake = 1'b0;
        sin = 1'b1;
        nxt();
        nxt();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_det_en", det_en, 0);
        chk("arst_dv", dout_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_start", tx_start, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_cnt", frame_cnt, 0);
        exp_cnt = 0;
        nxt();
        rst = 1'b0;
        gb = 1'b0;
        det_wake = 1'b1;
        nxt();
        det_wake = 1'b0;
        #1;
        chk("wake_ignored_busy", busy, 0);
        chk("wake_ignored_det_en", det_en, 0);
        nxt();
        #1;
        chk("still_idle", busy, 0);
        gb = 1'b1;
        nxt();
        #1;
        chk("post_rst_hunt", det_en, 1);
        sb_bits("arst");

        // 256 back-to-back length-1 frames: the counter must wrap to 0.
        for (int f = 0; f < 256; f++) begin
            run_frame(1, 16'($urandom), 0, 1, 1'b0, 1'b0);
        end
        chk("wrap", frame_cnt, 0);

        // Randomized frames with handshake delays, gb drops and stray wakes.
        for (int f = 0; f < 40; f++) begin
            run_frame($urandom_range(0, (1 << CNT_W) - 1), 16'($urandom),
                      $urandom_range(0, 3), $urandom_range(1, 4),
                      ($urandom_range(0, 7) == 0), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
